mem_access: RTL and testbench

- Memory-access pipeline stage between the EX/MEM register and the MEM/WB register.
- Executes loads, stores, LL and SC as multi-cycle transactions on a simple req/ack data bus. Holds the pipeline with `stallreq` while a transaction is outstanding.
- Produces the `mem_*` signals that MEM/WB latches. Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_access_pkg.sv | 52 +++++
 rtl/mem_access_lane_fmt.sv | 48 ++++
 rtl/mem_access.sv | 196 +++++++++++++++++++
 tb/tb_mem_access.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, aluop codes,
// FSM state encoding and opcode classification helpers.
package mem_access_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } mem_state_t;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP: is_mem_op = 1'b1;
            default:                                               is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP: is_store = 1'b1;
            default:                                   is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:           is_misaligned = addr_lo[0];
            EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP: is_misaligned = (addr_lo != 2'b00);
            default:                                    is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_lane_fmt.sv
// Big-endian byte-lane steering: bus select, replicated store data and
// sign/zero-extended load data for one memory access.
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  logic [7:0]        aluop,
    input  logic [1:0]        addr_lo,
    input  logic [RegBus-1:0] reg2,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] rdata_fmt
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    always_comb begin
        case (addr_lo)
            2'b00:   begin byte_lane = rdata[31:24]; byte_sel = 4'b1000; end
            2'b01:   begin byte_lane = rdata[23:16]; byte_sel = 4'b0100; end
            2'b10:   begin byte_lane = rdata[15:8];  byte_sel = 4'b0010; end
            default: begin byte_lane = rdata[7:0];   byte_sel = 4'b0001; end
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        half_sel  = addr_lo[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        sel       = 4'b0000;
        wdata     = '0;
        rdata_fmt = '0;
        case (aluop)
            EXE_LB_OP:  begin sel = byte_sel; rdata_fmt = {{24{byte_lane[7]}}, byte_lane}; end
            EXE_LBU_OP: begin sel = byte_sel; rdata_fmt = {24'd0, byte_lane}; end
            EXE_LH_OP:  begin sel = half_sel; rdata_fmt = {{16{half_lane[15]}}, half_lane}; end
            EXE_LHU_OP: begin sel = half_sel; rdata_fmt = {16'd0, half_lane}; end
            EXE_LW_OP, EXE_LL_OP: begin sel = 4'b1111; rdata_fmt = rdata; end
            EXE_SB_OP:  begin sel = byte_sel; wdata = {4{reg2[7:0]}}; end
            EXE_SH_OP:  begin sel = half_sel; wdata = {2{reg2[15:0]}}; end
            EXE_SW_OP, EXE_SC_OP: begin sel = 4'b1111; wdata = reg2; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores/LL/SC as req/ack bus transactions,
// stalling the pipeline while outstanding; other ops pass straight through.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [RegAddrBus-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [RegBus-1:0]     ex_wdata,
    input  logic [RegBus-1:0]     ex_hi,
    input  logic [RegBus-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [7:0]            ex_aluop,
    input  logic [RegBus-1:0]     ex_mem_addr,
    input  logic [RegBus-1:0]     ex_reg2,
    input  logic                  LLbit_i,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [RegBus-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [RegBus-1:0]     bus_wdata,
    input  logic [RegBus-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic [RegAddrBus-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [RegBus-1:0]     mem_wdata,
    output logic [RegBus-1:0]     mem_hi,
    output logic [RegBus-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic                  mem_LLbit_we,
    output logic                  mem_LLbit_value,
    output logic                  mem_addr_err,
    output logic                  mem_bus_err,
    output logic                  stallreq
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_expired;
    logic              start;
    logic [7:0]        op_q;
    logic [1:0]        addr_lo_q;
    logic [RegBus-1:0] cap_q;
    logic              bus_err_q;

    logic [7:0]        fmt_op;
    logic [1:0]        fmt_addr;
    logic [3:0]        fmt_sel;
    logic [RegBus-1:0] fmt_wdata;
    logic [RegBus-1:0] fmt_rdata;

    logic              unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    // In IDLE the lanes are computed from the incoming op to launch the bus
    // cycle; afterwards from the latched op so load data is formatted correctly.
    assign fmt_op   = (state == ST_IDLE) ? ex_aluop : op_q;
    assign fmt_addr = (state == ST_IDLE) ? ex_mem_addr[1:0] : addr_lo_q;

    mem_lane_fmt u_lane_fmt (
        .aluop     (fmt_op),
        .addr_lo   (fmt_addr),
        .reg2      (ex_reg2),
        .rdata     (bus_rdata),
        .sel       (fmt_sel),
        .wdata     (fmt_wdata),
        .rdata_fmt (fmt_rdata)
    );

    assign bus_req     = (state == ST_BUSY) || (state == ST_DRAIN);
    assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            addr_lo_q <= '0;
            cap_q     <= '0;
            bus_err_q <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                op_q      <= ex_aluop;
                addr_lo_q <= ex_mem_addr[1:0];
                bus_addr  <= {ex_mem_addr[RegBus-1:2], 2'b00};
                bus_sel   <= fmt_sel;
                bus_we    <= is_store(ex_aluop);
                bus_wdata <= fmt_wdata;
                cnt       <= '0;
                bus_err_q <= 1'b0;
            end else if (bus_req && (cnt != CNT_W'(TIMEOUT))) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == ST_BUSY) && !flush) begin
                if (bus_ack) begin
                    if (op_q == EXE_SC_OP)
                        cap_q <= 32'd1;
                    else if (is_store(op_q))
                        cap_q <= '0;
                    else
                        cap_q <= fmt_rdata;
                end else if (cnt_expired) begin
                    bus_err_q <= 1'b1;
                    cap_q     <= '0;
                end
            end
        end
    end

    always_comb begin
        state_next      = state;
        start           = 1'b0;
        stallreq        = NoStop;
        mem_wd          = ex_wd;
        mem_wreg        = ex_wreg;
        mem_wdata       = ex_wdata;
        mem_hi          = ex_hi;
        mem_lo          = ex_lo;
        mem_whilo       = ex_whilo;
        mem_LLbit_we    = 1'b0;
        mem_LLbit_value = 1'b0;
        mem_addr_err    = 1'b0;
        mem_bus_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_mem_op(ex_aluop)) begin
                    mem_wreg  = 1'b0;
                    mem_whilo = 1'b0;
                    mem_wdata = '0;
                    if (!flush) begin
                        if (is_misaligned(ex_aluop, ex_mem_addr[1:0])) begin
                            mem_addr_err = 1'b1;
                        end else if ((ex_aluop == EXE_SC_OP) && !LLbit_i) begin
                            mem_wreg = 1'b1;
                        end else begin
                            start      = 1'b1;
                            stallreq   = Stop;
                            state_next = ST_BUSY;
                        end
                    end
                end
            end
            ST_BUSY: begin
                stallreq  = Stop;
                mem_wreg  = 1'b0;
                mem_whilo = 1'b0;
                mem_wdata = '0;
                if (flush)
                    state_next = bus_ack ? ST_IDLE : ST_DRAIN;
                else if (bus_ack || cnt_expired)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                mem_wdata = cap_q;
                mem_whilo = 1'b0;
                if (bus_err_q) begin
                    mem_bus_err = 1'b1;
                    mem_wreg    = 1'b0;
                end else if (op_q == EXE_LL_OP) begin
                    mem_LLbit_we    = 1'b1;
                    mem_LLbit_value = 1'b1;
                end else if (op_q == EXE_SC_OP) begin
                    mem_LLbit_we    = 1'b1;
                    mem_LLbit_value = 1'b0;
                end else if (is_store(op_q)) begin
                    mem_wreg = 1'b0;
                end
                if (!stall[4] || flush)
                    state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                // Bus cycle must complete before the bus is released; result is dropped.
                stallreq  = Stop;
                mem_wreg  = 1'b0;
                mem_whilo = 1'b0;
                mem_wdata = '0;
                if (bus_ack)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomised and directed bench for mem_access with an arithmetic reference
// model of lane selection, load extension and transaction timing.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr, ex_reg2;
    logic        LLbit_i;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        mem_whilo, mem_LLbit_we, mem_LLbit_value, mem_addr_err, mem_bus_err;
    logic        stallreq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ops [10] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                             EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP};

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .LLbit_i(LLbit_i),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_LLbit_we(mem_LLbit_we),
        .mem_LLbit_value(mem_LLbit_value), .mem_addr_err(mem_addr_err),
        .mem_bus_err(mem_bus_err), .stallreq(stallreq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 4;
    endfunction

    function automatic bit op_is_store(input logic [7:0] op);
        return (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP || op == EXE_SC_OP);
    endfunction

    // Big-endian: a size-sz item at byte offset off sits (4-sz-off) bytes above bit 0.
    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int sz, off;
        logic [31:0] v;
        sz  = op_size(op);
        off = int'(addr % 4);
        v   = rdata >> (8 * (4 - sz - off));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op == EXE_LB_OP && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op == EXE_LH_OP && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
        int sz, off;
        sz  = op_size(op);
        off = int'(addr % 4);
        return 4'(((1 << sz) - 1) << (4 - sz - off));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] reg2);
        int sz;
        sz = op_size(op);
        if (sz == 1) return {24'd0, reg2[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'd0, reg2[15:0]} * 32'h0001_0001;
        return reg2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0;
        ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0; LLbit_i = 1'b0;
        flush = 1'b0; stall = '0; bus_ack = 1'b0; bus_rdata = '0;
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] reg2, input logic llbit);
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; LLbit_i = llbit;
        ex_wd = 5'($urandom_range(1, 31));
        ex_wreg = !op_is_store(op) || (op == EXE_SC_OP);
        ex_wdata = addr; ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'b0;
    endtask

    task automatic passthru(input string tag);
        ex_aluop = 8'($urandom_range(0, 8'hDF));
        ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
        ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'($urandom);
        #1;
        chk({tag, "_wdata"}, mem_wdata, ex_wdata);
        chk({tag, "_ctl"}, {mem_wd, mem_wreg, mem_whilo, stallreq, bus_req},
            {ex_wd, ex_wreg, ex_whilo, 1'b0, 1'b0});
        chk({tag, "_hilo"}, {mem_hi, mem_lo}, {ex_hi, ex_lo});
    endtask

    task automatic run_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                              input logic llbit, input int ack_after, input logic [31:0] rdata,
                              input int hold_done);
        int sz, n_stall;
        bit mis, scfail, st;
        sz = op_size(op);
        mis = (addr % sz) != 0;
        scfail = (op == EXE_SC_OP) && !llbit;
        st = op_is_store(op);
        n_stall = 0;
        drive_op(op, addr, reg2, llbit);
        #1;
        if (mis) begin
            chk("misalign", {mem_addr_err, mem_wreg, stallreq, bus_req}, 4'b1000);
            step();
            chk("misalign_nobus", bus_req, 1'b0);
            set_nop();
            return;
        end
        if (scfail) begin
            chk("scfail_wdata", mem_wdata, 32'd0);
            chk("scfail_ctl", {mem_wreg, stallreq, bus_req, mem_addr_err}, 4'b1000);
            step();
            chk("scfail_nobus", bus_req, 1'b0);
            set_nop();
            return;
        end
        chk("start", {stallreq, bus_req}, 2'b10);
        n_stall += int'(stallreq);
        step();
        chk("busy_addr", bus_addr, addr & 32'hFFFF_FFFC);
        chk("busy_sel", bus_sel, ref_sel(op, addr));
        chk("busy_we", bus_we, st);
        if (st) chk("busy_wdata", bus_wdata, ref_wdata(op, reg2));
        for (int i = 1; i <= ack_after; i++) begin
            chk("busy_req", bus_req, 1'b1);
            n_stall += int'(stallreq);
            if (i == ack_after) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end
            step();
            bus_ack = 1'b0;
            bus_rdata = $urandom;
        end
        #1;
        chk("stall_cycles", n_stall, ack_after + 1);
        chk("done_ctl", {stallreq, bus_req, mem_bus_err, mem_addr_err}, 4'b0000);
        chk("done_wreg", {mem_wd, mem_wreg}, {ex_wd, ex_wreg});
        chk("done_llbit", {mem_LLbit_we, mem_LLbit_value},
            (op == EXE_LL_OP) ? 2'b11 : (op == EXE_SC_OP) ? 2'b10 : 2'b00);
        if (op == EXE_SC_OP) chk("done_sc", mem_wdata, 32'd1);
        else if (!st) chk("done_load", mem_wdata, ref_load(op, addr, rdata));
        if (hold_done > 0) begin
            stall = 6'b011111;
            for (int i = 0; i < hold_done; i++) begin
                step();
                chk("done_hold", {stallreq, bus_req, mem_LLbit_we},
                    {2'b00, (op == EXE_LL_OP) || (op == EXE_SC_OP)});
                if (!st) chk("done_hold_data", mem_wdata, ref_load(op, addr, rdata));
            end
            stall = '0;
        end
        step();
        set_nop();
        passthru("after_done");
    endtask

    initial begin
        int busy;
        logic [7:0]  op;
        logic [31:0] addr;
        rst = 1'b1;
        set_nop();
        step();
        step();
        chk("rst_bus", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, '0);
        chk("rst_mem", {mem_wdata, mem_wreg, stallreq, mem_addr_err, mem_bus_err, mem_LLbit_we}, '0);
        rst = 1'b0;
        step();

        // ALU pass-through
        ex_aluop = 8'h25; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234;
        #1;
        chk("alu_wdata", mem_wdata, 32'h1234);
        chk("alu_ctl", {mem_wd, mem_wreg, stallreq, bus_req}, {5'd3, 3'b100});
        passthru("alu_rand");
        step();

        run_access(EXE_LB_OP, 32'h101, 32'h0, 1'b0, 3, 32'h11F2_3344, 2);
        run_access(EXE_SH_OP, 32'h202, 32'hABCD, 1'b0, 2, $urandom, 0);
        run_access(EXE_LW_OP, 32'h3, 32'h0, 1'b0, 1, 32'h0, 0);
        run_access(EXE_SC_OP, 32'h40, 32'h55, 1'b0, 1, 32'h0, 0);
        run_access(EXE_LL_OP, 32'h80, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, 0);
        run_access(EXE_SC_OP, 32'h80, 32'h77, 1'b1, 2, 32'h0, 1);
        run_access(EXE_LHU_OP, 32'h92, 32'h0, 1'b0, 1, 32'h1234_8765, 0);

        // Timeout: no ack ever arrives
        drive_op(EXE_LW_OP, 32'h400, 32'h0, 1'b0);
        step();
        busy = 0;
        while (bus_req && busy < 40) begin
            busy++;
            step();
        end
        chk("timeout_cycles", busy, TO);
        chk("timeout_err", {mem_bus_err, mem_wreg, stallreq, mem_LLbit_we}, 4'b1000);
        step();
        set_nop();
        #1;
        chk("timeout_idle", {mem_bus_err, stallreq, bus_req}, 3'b000);
        passthru("timeout_after");

        // Flush while BUSY, ack two cycles later
        drive_op(EXE_LW_OP, 32'h500, 32'h0, 1'b0);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        ex_aluop = 8'h00; ex_wreg = 1'b1; ex_whilo = 1'b1;
        #1;
        chk("drain1", {bus_req, stallreq, mem_wreg, mem_whilo, mem_LLbit_we}, 5'b11000);
        step();
        chk("drain2", {bus_req, stallreq}, 2'b11);
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        step();
        bus_ack = 1'b0;
        #1;
        chk("drain_idle", {bus_req, stallreq, mem_wreg}, 3'b001);
        set_nop();

        // Ack and flush together in BUSY
        drive_op(EXE_LW_OP, 32'h504, 32'h0, 1'b0);
        step();
        flush = 1'b1;
        bus_ack = 1'b1;
        step();
        set_nop();
        #1;
        chk("ackflush_idle", {bus_req, stallreq, mem_bus_err}, 3'b000);
        passthru("ackflush_after");

        // Reset in the middle of a store
        drive_op(EXE_SW_OP, 32'h600, 32'h8765_4321, 1'b0);
        step();
        chk("pre_rst_busy", {bus_req, bus_we}, 2'b11);
        rst = 1'b1;
        set_nop();
        step();
        chk("midrst_bus", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, '0);
        chk("midrst_mem", {mem_wdata, mem_wreg, stallreq, mem_bus_err, mem_addr_err}, '0);
        rst = 1'b0;
        step();
        chk("post_rst_idle", {bus_req, stallreq}, 2'b00);

        for (int n = 0; n < 24; n++) begin
            op = ops[$urandom_range(0, 9)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(op_size(op)) - 1);
            run_access(op, addr, $urandom, 1'($urandom), $urandom_range(1, 5), $urandom,
                       $urandom_range(0, 1));
            if (n % 4 == 0) begin
                passthru("rand_pt");
                step();
                set_nop();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
